// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with valid/ready intake
// Frame config is clamped and latched on accept; all outputs are registered.
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        data_bits,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  input  logic [DIV_W-1:0]  clk_ratio,
  output logic              tx_active,
  output logic              frame_done,
  output logic              tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]       N_MIN = 4'd5;
  localparam logic [3:0]       N_MAX = 4'(DATA_W);
  localparam logic [DIV_W-1:0] R_MIN = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE   = {{DIV_W{1'b0}}, 1'b1};

  state_t            state;
  logic [DIV_W:0]    cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DIV_W-1:0]  r_lat;
  logic              par_en;
  logic              par_bit;
  logic              two_stop;

  logic [3:0]        n_in;
  logic [DIV_W-1:0]  r_in;
  logic [DATA_W-1:0] data_masked;
  logic              par_in;
  logic [DIV_W:0]    r_m1;
  logic [DIV_W:0]    r2_m1;

  always_comb begin
    n_in = data_bits;
    if (data_bits < N_MIN)
      n_in = N_MIN;
    else if (data_bits > N_MAX)
      n_in = N_MAX;
    r_in = (clk_ratio < R_MIN) ? R_MIN : clk_ratio;
    // Parity covers only the bits actually sent
    for (int i = 0; i < DATA_W; i++)
      data_masked[i] = data[i] & (i < int'(n_in));
    par_in = (^data_masked) ^ (parity_mode == 2'd2);
  end

  assign r_m1  = {1'b0, r_lat} - ONE;
  assign r2_m1 = {r_lat, 1'b0} - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      r_lat      <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      two_stop   <= 1'b0;
      tx         <= 1'b1;
      tx_active  <= 1'b0;
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg     <= data;
            bit_idx   <= n_in - 4'd1;
            r_lat     <= r_in;
            par_en    <= ^parity_mode;
            par_bit   <= par_in;
            two_stop  <= stop_bits;
            cnt       <= {1'b0, r_in} - ONE;
            tx        <= 1'b0;
            tx_active <= 1'b1;
            tx_ready  <= 1'b0;
            state     <= START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            cnt   <= r_m1;
            state <= DATA;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            if (bit_idx == 4'd0) begin
              if (par_en) begin
                tx    <= par_bit;
                cnt   <= r_m1;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                cnt   <= two_stop ? r2_m1 : r_m1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
              bit_idx <= bit_idx - 4'd1;
              cnt     <= r_m1;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        PARITY: begin
          if (cnt == '0) begin
            tx    <= 1'b1;
            cnt   <= two_stop ? r2_m1 : r_m1;
            state <= STOP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            tx_active  <= 1'b0;
            tx_ready   <= 1'b1;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; the next generation of the team's uart_tx. It adds a valid/ready handshake, selectable data length, parity and stop bits, and a wider baud divider. It sits between a byte-producing host (CPU bridge, test sequencer) and the serial tx pin. It is clocked by the system clk, and each bit lasts clk_ratio clocks.

Parameters:
DATA_W, 8, maximum data bits per frame; legal range 5..9.
DIV_W, 8, width of the clk_ratio input.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
tx_valid  input  1  host has a character on data.
tx_ready  output  1  block can accept a character this cycle.
data  input  DATA_W  character to send, LSB first.
data_bits  input  4  bits per character; values below 5 clamp to 5, values above DATA_W clamp to DATA_W.
parity_mode  input  2  0 = none, 1 = even, 2 = odd, 3 = none.
stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
clk_ratio  input  DIV_W  clocks per bit; values 0 and 1 are treated as 2.
tx_active  output  1  frame in progress.
frame_done  output  1  one-cycle pulse at the end of the frame.
tx  output  1  serial line; idle high.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous assert, synchronous-to-clk release.
- Reset values: tx=1, tx_active=0, tx_ready=0, frame_done=0, FSM=IDLE, counters=0.
- tx_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when parity_mode is 0 or 3) -> STOP -> IDLE.
- tx_ready=1 only in IDLE.
- Accept: tx_valid && tx_ready sampled at clk edge E0.
  - At E0 the block latches data, data_bits, parity_mode, stop_bits and clk_ratio (after clamping).
  - Input changes after E0 do not affect the current frame.
- Timing after E0: tx=0, tx_active=1, tx_ready=0.
- Bit timing:
  - Each bit holds for exactly R latched clk_ratio cycles; the divider reloads at every bit boundary.
  - START holds 0.
  - DATA sends data[0]..data[N-1]; bits above N are ignored.
  - PARITY sends the XOR of the N sent bits; it is inverted for odd parity.
  - STOP holds 1 for R or 2R cycles.
- Frame length = (1 + N + P + S) * R cycles, where P is 0 or 1 and S is 1 or 2. tx_active is high for exactly this many cycles.
- End of frame:
  - On the edge that ends the last stop cycle, the FSM goes to IDLE, tx_active=0, tx_ready=1 and frame_done=1 for one cycle.
  - tx stays 1.
- Back-to-back frames:
  - A new character can be accepted in the first IDLE cycle.
  - tx is therefore high for the full stop time plus exactly one clk cycle between frames.
  - There is no lower bound on idle beyond that.
- tx_valid with tx_ready=0 is ignored. The host holds tx_valid and data until accepted; dropping tx_valid early is legal (no accept).
- Reset mid-frame: the frame is aborted immediately. tx=1 and tx_active=0 asynchronously, with no frame_done pulse.
- tx never glitches; it changes only on clk edges or on reset assertion.

Test Plan:
- 8N1, clk_ratio=100, data=0x55 -> tx low 100 cycles, then 1,0,1,0,1,0,1,0 at 100 cycles each, then high. tx_active high 1000 cycles; frame_done pulses once at the end.
- 7E1, R=100, data=0x99 -> data bits 1,0,0,1,1,0,0, parity=1; tx_active 1000 cycles. Then odd parity with the same data -> parity bit 0.
- 8O2, R=100, data=0xED -> parity=1; stop high 200 cycles; tx_active 1200 cycles. Change all config inputs mid-frame -> the frame is unchanged.
- Back-to-back with tx_valid held high, 0x01 then 0x55 (8N1, R=100) -> the second start bit falls exactly 101 cycles after the first frame's stop bit began. tx_ready is low throughout each frame.
- Clamps: clk_ratio=0 and clk_ratio=1 -> 2 cycles per bit. data_bits=3 -> 5 bits sent. data_bits=12 -> DATA_W bits sent.
- Reset asserted 450 cycles into a frame -> tx=1, tx_active=0 with no clk edge, no frame_done. After release, tx_ready=1 one edge later and the next frame is correct.
